lcd_host_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single `hd44780_parallel_lcd` host port between `NUM_REQ` independent requesters, for example the FIFO adapter and a UART-RX status writer. A grant is held for a whole packet, so a multi-transaction sequence cannot be interleaved with another requester's characters. A packet is, for example, a set-DDRAM-address command followed by its characters. The block sits between the requesters and `u_lcd`, and gates all traffic on `init_done`.

---
 rtl/lcd_host_arbiter.sv | 155 +++++++++++++++
 tb/tb_lcd_host_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_host_arbiter.sv
// Packet-level round-robin arbiter sharing one HD44780 host port between NUM_REQ requesters.
// A grant lasts a whole packet; a watchdog releases it when the owner goes quiet mid-packet.
module lcd_host_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_done,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_rs,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       host_valid,
  output logic                       host_rs,
  output logic [7:0]                 host_data,
  input  logic                       host_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] PTR_RESET = GW'(NUM_REQ - 1);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_GRANT  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] last_ptr_q, last_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          busy_q, busy_d;
  logic          timeout_pulse_q, timeout_pulse_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  logic          pick_found_s;
  logic [GW-1:0] pick_idx_s;
  logic [GW:0]   cand_s;
  logic          in_grant_s;
  logic          sel_valid_s, sel_rs_s, sel_last_s;
  logic [7:0]    sel_data_s;
  logic          fire_s;
  logic          wd_hit_s;

  // Round-robin search upward from last_ptr+1; the extra cand_s bit absorbs the wrap.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s       = {1'b0, last_ptr_q} + (GW+1)'(k + 1);
      cand_s       = (cand_s >= (GW+1)'(NUM_REQ)) ? cand_s - (GW+1)'(NUM_REQ) : cand_s;
      pick_idx_s   = (!pick_found_s && req_valid[cand_s]) ? cand_s[GW-1:0] : pick_idx_s;
      pick_found_s = pick_found_s | req_valid[cand_s];
    end
  end

  assign in_grant_s  = (state_q == ST_GRANT);
  assign sel_valid_s = req_valid[grant_id_q];
  assign sel_rs_s    = req_rs[grant_id_q];
  assign sel_last_s  = req_last[grant_id_q];
  assign sel_data_s  = req_data[{grant_id_q, 3'b000} +: 8];
  assign fire_s      = in_grant_s & sel_valid_s & host_ready;
  assign wd_hit_s    = (TIMEOUT_CYCLES > 0) && in_grant_s && !fire_s && (wd_cnt_q == TO_LIMIT);

  // Pass the owner's beat straight through; host_valid never depends on host_ready.
  always_comb begin
    req_ready  = '0;
    host_valid = 1'b0;
    host_rs    = 1'b0;
    host_data  = 8'h00;
    if (in_grant_s) begin
      req_ready[grant_id_q] = host_ready;
      host_valid            = sel_valid_s;
      host_rs               = sel_rs_s;
      host_data             = sel_data_s;
    end else begin
      req_ready = '0;
    end
  end

  // Grant/release sequencing and the mid-packet watchdog.
  always_comb begin
    state_d         = state_q;
    last_ptr_d      = last_ptr_q;
    grant_id_d      = grant_id_q;
    busy_d          = busy_q;
    timeout_pulse_d = 1'b0;
    wd_cnt_d        = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (init_done && pick_found_s) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_idx_s;
          busy_d     = 1'b1;
          wd_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (fire_s) begin
          wd_cnt_d = '0;
          if (sel_last_s) begin
            state_d    = ST_IDLE;
            last_ptr_d = grant_id_q;
            busy_d     = 1'b0;
          end else begin
            state_d = ST_GRANT;
          end
        end else if (wd_hit_s) begin
          state_d         = ST_IDLE;
          last_ptr_d      = grant_id_q;
          busy_d          = 1'b0;
          timeout_pulse_d = 1'b1;
          wd_cnt_d        = '0;
        end else if ((TIMEOUT_CYCLES > 0) && !sel_valid_s) begin
          wd_cnt_d = wd_cnt_q + CW'(1);
        end else begin
          wd_cnt_d = wd_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset puts requester 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_ptr_q      <= PTR_RESET;
      grant_id_q      <= '0;
      busy_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
      wd_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      last_ptr_q      <= last_ptr_d;
      grant_id_q      <= grant_id_d;
      busy_q          <= busy_d;
      timeout_pulse_q <= timeout_pulse_d;
      wd_cnt_q        <= wd_cnt_d;
    end
  end

  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_lcd_host_arbiter.sv
// Testbench for lcd_host_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_lcd_host_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init_done = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_rs = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              host_valid, host_rs;
  logic [7:0]        host_data;
  logic              host_ready = 1'b0;
  logic [1:0]        grant_id;
  logic              busy, timeout_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_host_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .host_valid(host_valid), .host_rs(host_rs), .host_data(host_data),
    .host_ready(host_ready), .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 when nobody holds the port), rotation pointer, quiet-cycle count.
  int   m_owner  = -1;
  int   m_last   = NREQ - 1;
  int   m_gid    = 0;
  int   m_silent = 0;
  logic m_tp     = 1'b0;

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    rr_pick = -1;
    for (int j = NREQ; j >= 1; j--) if (v[(last + j) % NREQ]) rr_pick = (last + j) % NREQ;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_last <= NREQ - 1; m_gid <= 0; m_silent <= 0; m_tp <= 1'b0;
    end else begin
      m_tp <= 1'b0;
      if (m_owner < 0) begin
        if (init_done && rr_pick(m_last, req_valid) >= 0) begin
          m_owner  <= rr_pick(m_last, req_valid);
          m_gid    <= rr_pick(m_last, req_valid);
          m_silent <= 0;
        end
      end else if (req_valid[m_owner] && host_ready) begin
        m_silent <= 0;
        if (req_last[m_owner]) begin m_last <= m_owner; m_owner <= -1; end
      end else if (m_silent == TO) begin
        m_tp <= 1'b1; m_last <= m_owner; m_owner <= -1; m_silent <= 0;
      end else if (!req_valid[m_owner]) begin
        m_silent <= m_silent + 1;
      end
    end
  end

  logic [NREQ-1:0] exp_rr;
  logic            exp_hv, exp_rs, exp_busy;
  logic [7:0]      exp_hd;
  logic [16:0]     obs_v, exp_v;

  always_comb begin
    exp_rr = '0; exp_hv = 1'b0; exp_rs = 1'b0; exp_hd = 8'h00; exp_busy = 1'b0;
    if (m_owner >= 0) begin
      exp_rr[m_owner] = host_ready;
      exp_hv   = req_valid[m_owner];
      exp_rs   = req_rs[m_owner];
      exp_hd   = req_data[m_owner*8 +: 8];
      exp_busy = 1'b1;
    end
  end

  assign obs_v = {req_ready, host_valid, host_rs, host_data, grant_id, busy, timeout_pulse};
  assign exp_v = {exp_rr, exp_hv, exp_rs, exp_hd, 2'(m_gid), exp_busy, m_tp};

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b1; host_ready = 1'b1;
    req_valid = '1; req_last = '1; req_rs = '1; req_data = 24'hA5A5A5;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_v !== 17'h0) $display("FAIL reset_outputs: got %h expected %h", obs_v, 17'h0);
    else n_pass++;
    req_valid = '0; req_last = '0; req_rs = '0; req_data = '0; host_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_init_gating();
    int bad = 0;
    @(negedge clk);
    init_done = 1'b0; req_valid = 3'b001; req_last = 3'b001; req_data = 24'h000012;
    repeat (100) begin
      @(negedge clk);
      if (host_valid !== 1'b0 || busy !== 1'b0) bad++;
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_init: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL init_gate: got %0d granted cycles expected 0", bad);
    else n_pass++;
    init_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant_id} !== {1'b1, 2'd0}) $display("FAIL init_grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
    else n_pass++;
    host_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL model_init_end: got %h expected %h", obs_v, exp_v);
    else n_pass++;
  endtask

  // Requester 0 owned last, so rotation starts with requester 1.
  task automatic test_round_robin();
    logic [1:0] want_id;
    @(negedge clk);
    req_valid = 3'b011; req_last = 3'b011; req_rs = 3'b011; req_data = 24'h003130; host_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      want_id = ((k / 2) % 2 == 0) ? 2'd1 : 2'd0;
      n_checks++;
      if (k % 2 == 0) begin
        if ({busy, grant_id, host_data} !== {1'b1, want_id, 6'h0C, want_id})
          $display("FAIL rr_grant_%0d: got busy=%b id=%0d data=%h expected busy=1 id=%0d", k, busy, grant_id, host_data, want_id);
        else n_pass++;
      end else begin
        if (busy !== 1'b0) $display("FAIL rr_bubble_%0d: got busy=%b expected 0", k, busy);
        else n_pass++;
      end
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rr: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
    end
    req_valid = '0;
  endtask

  task automatic test_packet_lock();
    logic [10:0]     seen[$];
    int              seen_cyc[$];
    logic [10:0]     want [4];
    logic [7:0]      d1 [3];
    logic            r1s [3];
    logic [NREQ-1:0] fired;
    int              b1 = 0;
    bit              r0_on = 1'b0, r0_done = 1'b0;
    want[0] = {2'd1, 1'b0, 8'h80}; want[1] = {2'd1, 1'b1, 8'h41};
    want[2] = {2'd1, 1'b1, 8'h42}; want[3] = {2'd0, 1'b1, 8'h55};
    d1 = '{8'h80, 8'h41, 8'h42}; r1s = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    host_ready = 1'b1; req_last = '0;
    req_valid[1] = 1'b1; req_rs[1] = r1s[0]; req_data[15:8] = d1[0];
    for (int c = 0; c < 20 && !r0_done; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_lock: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
      if (host_valid && host_ready) begin
        seen.push_back({grant_id, host_rs, host_data});
        seen_cyc.push_back(c);
      end
      fired = req_valid & req_ready;
      @(posedge clk); #1;
      if (fired[1]) begin
        b1++;
        if (b1 < 3) begin
          req_rs[1] = r1s[b1]; req_data[15:8] = d1[b1]; req_last[1] = (b1 == 2);
        end else begin
          req_valid[1] = 1'b0; req_last[1] = 1'b0;
        end
      end
      if (fired[0]) begin req_valid[0] = 1'b0; req_last[0] = 1'b0; r0_done = 1'b1; end
      if (b1 >= 1 && !r0_on) begin
        r0_on = 1'b1; req_valid[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h55; req_last[0] = 1'b1;
      end
    end
    n_checks++;
    if (seen.size() != 4) $display("FAIL lock_count: got %0d beats expected 4", seen.size());
    else n_pass++;
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      n_checks++;
      if (seen[i] !== want[i]) $display("FAIL lock_beat_%0d: got %h expected %h", i, seen[i], want[i]);
      else n_pass++;
    end
    n_checks++;
    if (!(seen.size() == 4 && seen_cyc[1] == seen_cyc[0] + 1 && seen_cyc[2] == seen_cyc[1] + 1 && seen_cyc[3] == seen_cyc[2] + 2))
      $display("FAIL lock_timing: got %0d beats, cycle gaps not 1,1,2 expected contiguous packet then one bubble", seen.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    @(negedge clk);
    host_ready = 1'b0;
    req_valid[1] = 1'b1; req_rs[1] = 1'b1; req_data[15:8] = 8'h33; req_last[1] = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (timeout_pulse !== 1'b0 || host_data !== 8'h33 || req_ready !== 3'b000 || busy !== 1'b1) bad++;
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_bp: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL backpressure: got %0d bad cycles expected 0", bad);
    else n_pass++;
    host_ready = 1'b1;
    @(posedge clk); #1;
    req_data[15:8] = 8'h34; req_last[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_v !== exp_v) $display("FAIL model_bp_last: got %h expected %h", obs_v, exp_v);
    else n_pass++;
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
  endtask

  // Counted from the fire cycle: quiet from +1, counter hits TO at +TO+1, pulse at +TO+2.
  task automatic test_watchdog();
    int pulses = 0, pulse_cyc = -1, grant_cyc = -1;
    logic busy_at_pulse = 1'b1;
    @(negedge clk);
    host_ready = 1'b1;
    req_valid[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h11; req_last[0] = 1'b0;
    req_valid[1] = 1'b1; req_rs[1] = 1'b1; req_data[15:8] = 8'h22; req_last[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant_id} !== {1'b1, 2'd0}) $display("FAIL wd_first_grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
    else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int c = 1; c < 300 && grant_cyc < 0; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_wd: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
      if (timeout_pulse) begin
        pulses++;
        if (pulse_cyc < 0) begin pulse_cyc = c; busy_at_pulse = busy; end
      end
      if (pulse_cyc >= 0 && busy && grant_id == 2'd1) grant_cyc = c;
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    n_checks++;
    if (pulses != 1 || pulse_cyc != TO + 2 || busy_at_pulse !== 1'b0)
      $display("FAIL wd_pulse: got %0d pulses at cycle %0d busy=%b expected 1 pulse at cycle %0d busy=0", pulses, pulse_cyc, busy_at_pulse, TO + 2);
    else n_pass++;
    n_checks++;
    if (grant_cyc != TO + 3) $display("FAIL wd_next_grant: got requester 1 at cycle %0d expected %0d", grant_cyc, TO + 3);
    else n_pass++;
  endtask

  // Before reset requester 1 would be next; after reset requester 0 must win.
  task automatic test_reset_mid();
    @(negedge clk);
    host_ready = 1'b0;
    req_valid[0] = 1'b1; req_rs[0] = 1'b1; req_data[7:0] = 8'h77; req_last[0] = 1'b0;
    req_valid[1] = 1'b1; req_rs[1] = 1'b1; req_data[15:8] = 8'h66; req_last[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant_id} !== {1'b1, 2'd0}) $display("FAIL rst_pre_grant: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_v !== 17'h0) $display("FAIL rst_mid_outputs: got %h expected %h", obs_v, 17'h0);
    else n_pass++;
    req_last[0] = 1'b1; host_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, grant_id} !== {1'b1, 2'd0}) $display("FAIL rst_priority: got busy=%b id=%0d expected busy=1 id=0", busy, grant_id);
    else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rst: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
  endtask

  task automatic test_random();
    int              left [NREQ];
    int              gap [NREQ];
    logic [NREQ-1:0] fired;
    for (int i = 0; i < NREQ; i++) begin left[i] = 0; gap[i] = $urandom_range(0, 3); end
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL model_rand: got %h expected %h at %0t", obs_v, exp_v, $time);
      else n_pass++;
      fired = req_valid & req_ready;
      @(posedge clk); #1;
      init_done  = ($urandom_range(0, 29) != 0);
      host_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && fired[i]) begin
          req_valid[i] = 1'b0;
          left[i]--;
          if (left[i] == 0) gap[i] = $urandom_range(0, 4);
          else if ($urandom_range(0, 15) == 0) gap[i] = $urandom_range(100, 125);
          else gap[i] = $urandom_range(0, 2);
        end else if (!req_valid[i]) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            if (left[i] == 0) left[i] = $urandom_range(1, 4);
            req_valid[i] = 1'b1;
            req_rs[i] = 1'($urandom_range(0, 1));
            req_data[i*8 +: 8] = 8'($urandom);
            req_last[i] = (left[i] == 1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
